// File: rtl/obstacle_field_engine_if.sv
// -----------------------------------------------------------------------------
// obstacle_field_engine_if
//
// Bundles the signals exchanged between the game FSM / display side and the
// obstacle field engine. Clock and reset stay as plain ports on the engine.
//
//   state        game FSM state: 00 START, 01 PLAYING, 10 INSTRUCTIONS,
//                11 GAME_OVER
//   key_left     active-low pushbutton, already synchronised upstream
//   key_right    active-low pushbutton, already synchronised upstream
//   player_lane  current player lane, 0..3
//   obstacle_map 4 bits per row; bits [4r+3:4r] are row r, bit k = lane k
//   collision    one-cycle pulse per new hit
//   tick         one-cycle pulse on each game step
//   score        ticks survived, saturating at 16'hFFFF
//
// Modports:
//   master  the game side: drives state and keys, observes the engine outputs
//   slave   the engine itself
// -----------------------------------------------------------------------------
interface obstacle_field_engine_if #(
  parameter int unsigned ROWS = 8
);

  logic [1:0]          state;
  logic                key_left;
  logic                key_right;
  logic [1:0]          player_lane;
  logic [4*ROWS-1:0]   obstacle_map;
  logic                collision;
  logic                tick;
  logic [15:0]         score;

  modport master (
    output state,
    output key_left,
    output key_right,
    input  player_lane,
    input  obstacle_map,
    input  collision,
    input  tick,
    input  score
  );

  modport slave (
    input  state,
    input  key_left,
    input  key_right,
    output player_lane,
    output obstacle_map,
    output collision,
    output tick,
    output score
  );

endinterface : obstacle_field_engine_if

// File: rtl/obstacle_field_engine.sv
// -----------------------------------------------------------------------------
// obstacle_field_engine
//
// Gameplay core feeding the game FSM's collision input. Keeps the player lane
// and a ROWS-deep, 4-lane obstacle field that scrolls one row toward the
// player on every game tick. New rows come from a 16-bit Fibonacci LFSR and
// are never fully blocked. A hit on row 0 raises a registered one-cycle
// collision pulse and opens an invulnerability window of INVULN_TICKS ticks.
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   obstacle_field_engine_if.slave (state, keys in; lane, map,
//         collision, tick, score out)
//
// Parameters:
//   TICK_DIV      clock cycles per game step (>= 2)
//   ROWS          field depth (>= 2); row 0 is the player row, ROWS-1 spawns
//   INVULN_TICKS  ticks of hit immunity after a collision (>= 1)
//   LFSR_SEED     LFSR reset value (nonzero)
//
// State handling:
//   START         clears field, score, invulnerability and tick counter,
//                 recentres the lane; the LFSR keeps running state so each
//                 game gets a different field
//   PLAYING       everything live
//   INSTRUCTIONS,
//   GAME_OVER     everything frozen so the display keeps the final picture
// -----------------------------------------------------------------------------
module obstacle_field_engine #(
  parameter int unsigned TICK_DIV     = 2500000,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned INVULN_TICKS = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  obstacle_field_engine_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Local types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_START        = 2'b00,
    ST_PLAYING      = 2'b01,
    ST_INSTRUCTIONS = 2'b10,
    ST_GAME_OVER    = 2'b11
  } game_state_e;

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned IV_W  = $clog2(INVULN_TICKS + 1);
  localparam int unsigned MAP_W = 4 * ROWS;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
  localparam logic [IV_W-1:0]  INVULN_LOAD = IV_W'(INVULN_TICKS);

  // ---------------------------------------------------------------------------
  // Spawn pattern for the next top row, taken from the current LFSR value.
  // A quarter of the time (bits 7:6 == 0) the row is empty; otherwise the low
  // nibble is used, and if that would block all four lanes one lane chosen by
  // bits 5:4 is opened so the player always has an escape.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] spawn_row(input logic [15:0] lfsr);
    logic [3:0] row;
    row = lfsr[3:0];
    if (lfsr[7:6] == 2'b00) begin
      row = 4'h0;
    end else if (lfsr[3:0] == 4'hF) begin
      row[lfsr[5:4]] = 1'b0;
    end
    return row;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic              key_left_q,  key_left_d;
  logic              key_right_q, key_right_d;
  logic [1:0]        lane_q,      lane_d;
  logic [MAP_W-1:0]  map_q,       map_d;
  logic              collision_q, collision_d;
  logic              tick_q,      tick_d;
  logic [15:0]       score_q,     score_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [IV_W-1:0]   invuln_q,    invuln_d;
  logic [15:0]       lfsr_q,      lfsr_d;

  // ---------------------------------------------------------------------------
  // Decoded inputs and helper terms
  // ---------------------------------------------------------------------------
  game_state_e game_state;
  logic        playing;
  logic        press_left;
  logic        press_right;
  logic [3:0]  row0;
  logic        hit;
  logic        lfsr_fb;

  assign game_state = game_state_e'(bus.state);
  assign playing    = (game_state == ST_PLAYING);

  // Active-low buttons: a press is the 1 -> 0 transition against last cycle.
  assign press_left  = key_left_q  & ~bus.key_left;
  assign press_right = key_right_q & ~bus.key_right;

  // Hit test always looks at the registered map and lane, i.e. the field and
  // lane as they are before this cycle's shift or move.
  assign row0 = map_q[3:0];
  assign hit  = row0[lane_q];

  // x^16 + x^14 + x^13 + x^11 + 1, shifting left with feedback into bit 0.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    key_left_d  = bus.key_left;
    key_right_d = bus.key_right;
    lane_d      = lane_q;
    map_d       = map_q;
    collision_d = 1'b0;
    tick_d      = 1'b0;
    score_d     = score_q;
    cnt_d       = cnt_q;
    invuln_d    = invuln_q;
    lfsr_d      = lfsr_q;

    case (game_state)
      ST_START: begin
        lane_d   = 2'd1;
        map_d    = '0;
        score_d  = '0;
        cnt_d    = '0;
        invuln_d = '0;
      end

      ST_PLAYING: begin
        // Game step: tick_q is high exactly in the cycle the tick output is
        // shown, so all per-step updates happen on that cycle's closing edge.
        if (tick_q) begin
          map_d  = {spawn_row(lfsr_q), map_q[MAP_W-1:4]};
          lfsr_d = {lfsr_q[14:0], lfsr_fb};
          if (score_q != 16'hFFFF) begin
            score_d = score_q + 16'd1;
          end
          if (invuln_q != '0) begin
            invuln_d = invuln_q - IV_W'(1);
          end
        end

        // Written after the decrement so a fresh hit reloads the window even
        // when a tick lands in the same cycle.
        if (hit && (invuln_q == '0)) begin
          collision_d = 1'b1;
          invuln_d    = INVULN_LOAD;
        end

        // Both buttons in the same cycle cancel out.
        if (press_left && !press_right) begin
          if (lane_q != 2'd0) begin
            lane_d = lane_q - 2'd1;
          end
        end else if (press_right && !press_left) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
          end
        end

        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // INSTRUCTIONS / GAME_OVER: hold everything. tick_d and collision_d
        // stay at their zero defaults, which also drops a step that was
        // pending when PLAYING was left.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge value of every other register.
      key_left_q  <= 1'b1;
      key_right_q <= 1'b1;
      lane_q      <= 2'd1;
      map_q       <= '0;
      collision_q <= 1'b0;
      tick_q      <= 1'b0;
      score_q     <= '0;
      cnt_q       <= '0;
      invuln_q    <= '0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      key_left_q  <= key_left_d;
      key_right_q <= key_right_d;
      lane_q      <= lane_d;
      map_q       <= map_d;
      collision_q <= collision_d;
      tick_q      <= tick_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      invuln_q    <= invuln_d;
      lfsr_q      <= lfsr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.player_lane  = lane_q;
  assign bus.obstacle_map = map_q;
  assign bus.collision    = collision_q;
  assign bus.score        = score_q;
  // A step that was pending when PLAYING was left is never shown.
  assign bus.tick         = tick_q & playing;

endmodule : obstacle_field_engine

// File: tb/tb_obstacle_field_engine.sv
// -----------------------------------------------------------------------------
// tb_obstacle_field_engine
//
// Directed bench for obstacle_field_engine with a small game model. The model
// keeps the field as an array of rows, the lane/score/invulnerability as
// integers, and applies the game rules once per clock; a compare process
// checks every DUT output against it on each falling edge. Directed sections
// add literal expectations for the first spawned rows, lane moves, freeze,
// restart timing and reset during a hit.
// -----------------------------------------------------------------------------
module tb_obstacle_field_engine;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned ROWS     = 8;
  localparam int unsigned INVULN   = 4;
  localparam logic [15:0] SEED     = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  obstacle_field_engine_if #(.ROWS(ROWS)) bus ();

  obstacle_field_engine #(
    .TICK_DIV     (TICK_DIV),
    .ROWS         (ROWS),
    .INVULN_TICKS (INVULN),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Game model
  // ---------------------------------------------------------------------------
  logic [3:0]  m_rows [ROWS];
  int          m_lane, m_score, m_inv, m_cnt;
  bit          m_pend, m_coll;
  logic [15:0] m_lfsr;
  bit          m_kl, m_kr;
  int          m_colls   = 0;
  int          m_ignored = 0;

  function automatic logic [3:0] m_spawn(input logic [15:0] l);
    int kind;
    int blocked;
    kind = (int'(l) >> 6) & 3;
    blocked = int'(l) & 15;
    if (kind == 0) return 4'h0;
    if (blocked == 15) blocked = blocked & ~(1 << ((int'(l) >> 4) & 3));
    return 4'(blocked);
  endfunction

  function automatic logic [4*ROWS-1:0] m_map();
    logic [4*ROWS-1:0] v;
    for (int r = 0; r < int'(ROWS); r++) v[4*r +: 4] = m_rows[r];
    return v;
  endfunction

  function automatic bit model_hit_now();
    return (bus.state == 2'b01) && m_rows[0][m_lane] && (m_inv == 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < int'(ROWS); r++) m_rows[r] = 4'h0;
    m_lane = 1; m_score = 0; m_inv = 0; m_cnt = 0;
    m_pend = 1'b0; m_coll = 1'b0; m_lfsr = SEED;
    m_kl = 1'b1; m_kr = 1'b1;
  endtask

  task automatic model_step();
    bit pl, pr, hit;
    pl = m_kl && !bus.key_left;
    pr = m_kr && !bus.key_right;
    m_kl = bus.key_left;
    m_kr = bus.key_right;
    case (bus.state)
      2'b00: begin
        for (int r = 0; r < int'(ROWS); r++) m_rows[r] = 4'h0;
        m_score = 0; m_inv = 0; m_cnt = 0; m_lane = 1;
        m_coll = 1'b0; m_pend = 1'b0;
      end
      2'b01: begin
        hit = m_rows[0][m_lane];
        m_coll = hit && (m_inv == 0);
        if (hit && m_inv != 0) m_ignored++;
        if (m_coll) m_colls++;
        if (m_pend) begin
          for (int r = 0; r < int'(ROWS) - 1; r++) m_rows[r] = m_rows[r+1];
          m_rows[ROWS-1] = m_spawn(m_lfsr);
          m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
          if (m_score < 65535) m_score++;
          if (m_inv > 0) m_inv--;
        end
        if (m_coll) m_inv = INVULN;
        if (pl && !pr && m_lane > 0) m_lane--;
        else if (pr && !pl && m_lane < 3) m_lane++;
        m_pend = (m_cnt == int'(TICK_DIV) - 1);
        m_cnt = (m_cnt + 1) % int'(TICK_DIV);
      end
      default: begin
        m_coll = 1'b0;
        m_pend = 1'b0;
      end
    endcase
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  bit prev_coll  = 1'b0;
  int dut_pulses = 0;

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("lane",      64'(bus.player_lane),  64'(m_lane));
      check("map",       64'(bus.obstacle_map), 64'(m_map()));
      check("collision", 64'(bus.collision),    64'(m_coll));
      check("tick",      64'(bus.tick),         64'(m_pend && bus.state == 2'b01));
      check("score",     64'(bus.score),        64'(m_score));
      check("spawn_row_full", 64'(bus.obstacle_map[4*ROWS-1 -: 4] == 4'hF), 64'(0));
      check("collision_back_to_back", 64'(bus.collision && prev_coll), 64'(0));
      if (bus.collision) dut_pulses++;
      prev_coll = bus.collision;
    end else begin
      prev_coll = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic press(input bit l, input bit r);
    bus.key_left  = !l;
    bus.key_right = !r;
    step(1);
    bus.key_left  = 1'b1;
    bus.key_right = 1'b1;
    step(1);
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4 * int'(TICK_DIV); i++) begin
      step(1);
      if (bus.tick) begin
        found = 1'b1;
        break;
      end
    end
    check(name, 64'(found), 64'(1));
  endtask

  task automatic wait_model_hit(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (model_hit_now()) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    check(name, 64'(found), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lane"},      64'(bus.player_lane),  64'(1));
    check({tag, "_map"},       64'(bus.obstacle_map), 64'(0));
    check({tag, "_collision"}, 64'(bus.collision),    64'(0));
    check({tag, "_tick"},      64'(bus.tick),         64'(0));
    check({tag, "_score"},     64'(bus.score),        64'(0));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int t_first, t_second, n, nticks;
  logic [4*ROWS-1:0] snap_map;
  int snap_score, snap_lane;

  initial begin
    bus.state     = 2'b00;
    bus.key_left  = 1'b1;
    bus.key_right = 1'b1;
    rst = 1'b0;

    // Reset values
    step(3);
    check_reset_values("reset");
    rst = 1'b1;
    step(2);
    cmp_en = 1'b1;

    // Ticks, score and first three spawned rows from seed ACE1:
    // ACE1 -> row 1, 59C3 -> row 3, B387 -> row 7.
    bus.state = 2'b01;
    wait_tick("tick1_seen");
    t_first = cyc;
    step(1);
    check("map_after_tick1",   64'(bus.obstacle_map), 64'(32'h1000_0000));
    check("score_after_tick1", 64'(bus.score),        64'(1));
    wait_tick("tick2_seen");
    t_second = cyc;
    check("tick_period", 64'(t_second - t_first), 64'(TICK_DIV));
    step(1);
    check("map_after_tick2",   64'(bus.obstacle_map), 64'(32'h3100_0000));
    check("score_after_tick2", 64'(bus.score),        64'(2));
    wait_tick("tick3_seen");
    step(1);
    check("map_after_tick3",   64'(bus.obstacle_map), 64'(32'h7310_0000));
    check("score_after_tick3", 64'(bus.score),        64'(3));

    // Lane moves: 1 -> 0 -> 0 -> 0, right twice -> 2, both together -> 2
    press(1'b1, 1'b0); check("lane_left1", 64'(bus.player_lane), 64'(0));
    press(1'b1, 1'b0); check("lane_left2", 64'(bus.player_lane), 64'(0));
    press(1'b1, 1'b0); check("lane_left3", 64'(bus.player_lane), 64'(0));
    press(1'b0, 1'b1); check("lane_right1", 64'(bus.player_lane), 64'(1));
    press(1'b0, 1'b1); check("lane_right2", 64'(bus.player_lane), 64'(2));
    press(1'b1, 1'b1); check("lane_both",   64'(bus.player_lane), 64'(2));

    // First collision: pulse one cycle after the hit, then silence
    wait_model_hit("first_hit_found");
    step(1);
    check("hit_pulse_high", 64'(bus.collision), 64'(1));
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("hit_pulse_single", 64'(bus.collision), 64'(0));
    end

    // Long run with a fixed key pattern
    nticks = 0;
    for (int lc = 1; lc < 10000 * int'(TICK_DIV) + 100; lc++) begin
      bus.key_left  = (lc % 13) != 0;
      bus.key_right = (lc % 11) != 0;
      step(1);
      if (bus.tick) nticks++;
      if (nticks >= 10000) break;
    end
    bus.key_left  = 1'b1;
    bus.key_right = 1'b1;
    check("long_run_ticks", 64'(nticks), 64'(10000));
    step(2);

    // Freeze in GAME_OVER mid-count; keys ignored
    for (int i = 0; i < 2 * int'(TICK_DIV); i++) begin
      if (m_cnt == 2) break;
      step(1);
    end
    bus.state  = 2'b11;
    snap_map   = m_map();
    snap_score = m_score;
    snap_lane  = m_lane;
    for (int i = 0; i < 3 * int'(TICK_DIV); i++) begin
      if (i == 2) begin
        bus.key_left = 1'b0;
      end else if (i == 5) begin
        bus.key_right = 1'b0;
      end else begin
        bus.key_left  = 1'b1;
        bus.key_right = 1'b1;
      end
      step(1);
      check("frozen_tick", 64'(bus.tick), 64'(0));
    end
    check("frozen_map",   64'(bus.obstacle_map), 64'(snap_map));
    check("frozen_score", 64'(bus.score),        64'(snap_score));
    check("frozen_lane",  64'(bus.player_lane),  64'(snap_lane));

    // START clears; back to PLAYING gives a full TICK_DIV before the tick
    bus.state = 2'b00;
    step(1);
    check("start_map",   64'(bus.obstacle_map), 64'(0));
    check("start_score", 64'(bus.score),        64'(0));
    check("start_lane",  64'(bus.player_lane),  64'(1));
    step(1);
    bus.state = 2'b01;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n++;
      if (bus.tick) break;
    end
    check("restart_tick_delay", 64'(n), 64'(TICK_DIV));

    // Reset in the same cycle as a hit kills the pending pulse
    wait_model_hit("reset_hit_found");
    rst = 1'b0;
    #1;
    check_reset_values("rst_now");
    step(2);
    check("rst_hold_collision", 64'(bus.collision), 64'(0));
    rst = 1'b1;
    #1;
    check_reset_values("rst_release");
    step(5);

    // Model bookkeeping against the DUT
    check("pulse_count",       64'(dut_pulses),      64'(m_colls));
    check("pulses_seen",       64'(dut_pulses > 0),  64'(1));
    check("ignored_hits_seen", 64'(m_ignored > 0),   64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_obstacle_field_engine

// File: doc/obstacle_field_engine.md
Name: obstacle_field_engine

Overview:
- Gameplay engine on the producer side of the game FSM's `collision` input; consumes the FSM's 2-bit `state`.
- Holds the player lane and a scrolling 4-lane obstacle field, driven by left/right keys and an internal game tick.
- Emits a one-cycle `collision` pulse per new hit, with an invulnerability window afterwards, plus a score for the display path.

Parameters:
- TICK_DIV, 2500000: clock cycles per game step; must be at least 2.
- ROWS, 8: obstacle field depth; row 0 is the player row, row ROWS-1 is the spawn row.
- INVULN_TICKS, 4: ticks during which further hits are ignored after a collision.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- state  in  2  game FSM state: 00 START, 01 PLAYING, 10 INSTRUCTIONS, 11 GAME_OVER
- key_left  in  1  active-low pushbutton
- key_right  in  1  active-low pushbutton
- player_lane  out  2  current lane, 0..3
- obstacle_map  out  4*ROWS  bits [4r+3:4r] are row r; bit k set = obstacle in lane k
- collision  out  1  registered one-cycle hit pulse
- tick  out  1  one-cycle pulse on each game step
- score  out  16  ticks survived, saturating

Behaviour:
- Reset (async, rst=0), values:
  - player_lane=1, obstacle_map=0, collision=0, tick=0, score=0
  - tick counter=0, invuln=0, lfsr=LFSR_SEED
  - key history registers=1
- Key edge detect: press = previous sample 1 and current sample 0. History registers update every cycle in every state.
- Lane move, PLAYING only:
  - Left press: lane-1, saturating at 0.
  - Right press: lane+1, saturating at 3.
  - Both pressed in the same cycle: no move.
- Tick counter, PLAYING only:
  - Counts 0..TICK_DIV-1 and wraps.
  - `tick`=1 in exactly the cycle after the counter holds TICK_DIV-1.
  - Outside PLAYING the counter is held and `tick`=0.
- On each tick (the cycle `tick` is asserted):
  - Row r <= row r+1 for r < ROWS-1; old row 0 is discarded.
  - Row ROWS-1 <= spawn pattern.
  - lfsr advances one step: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  - score += 1, saturating at 16'hFFFF.
  - invuln -= 1 if nonzero.
- Spawn pattern:
  - lfsr[7:6]==00 -> empty row.
  - Otherwise lfsr[3:0], with lane lfsr[5:4] forced clear if lfsr[3:0]==4'hF. A fully blocked row is never spawned.
- Collision detect, every cycle in PLAYING:
  - hit = bit player_lane of row 0, using the current registered map and lane.
  - hit and invuln==0 -> collision=1 next cycle (latency 1), and invuln <= INVULN_TICKS.
  - The pulse lasts exactly one cycle. Hits while invuln>0 are ignored.
- Simultaneous events:
  - Hit evaluation uses the pre-shift map and pre-move lane.
  - An invuln load takes precedence over a same-cycle decrement.
- Per-state handling:
  - START: synchronously clear obstacle_map, score, invuln and tick counter; lane=1; lfsr is NOT reloaded.
  - INSTRUCTIONS and GAME_OVER: all state frozen (the display still shows the final field and score); collision=0.
  - Leaving PLAYING mid-count discards the partial tick.
- Reset asserted at any time takes effect immediately and overrides everything, including a pulse in flight.

Test Plan:
- Reset then state=01, TICK_DIV=4: tick pulses every 4 cycles; score 0->1->2->3 after 3 ticks; lfsr sequence matches golden model from 16'hACE1.
- state=01, lane=1, three key_left presses (1->0 transitions): lane 1->0->0; then key_left and key_right pressed same cycle -> lane unchanged.
- Preload field so a lane-1 obstacle reaches row 0 with lane=1: collision high exactly 1 cycle, one cycle after row 0 bit 1 sets; no second pulse while obstacle stays. With INVULN_TICKS=4, a second obstacle arriving 2 ticks later gives no pulse; one arriving 5 ticks later pulses.
- Run 10000 ticks with assertions: no spawned row ever equals 4'hF; collision never high two consecutive cycles.
- state 01->11 mid-count: map, score and lane frozen, tick=0, keys ignored; state->00: map=0, score=0, lane=1; back to 01: first tick after full TICK_DIV cycles.
- Assert rst=0 in the same cycle as a hit: collision=0 immediately; after release all outputs are at reset values.
